chain_collector: RTL and testbench

Host-side receiver at the far end of the stacked-die daisy chain. It deserialises per-chip report frames arriving on the last die's `data_out`, checks each frame, and buffers the decoded records (chip ID, upper/lower power value) in a FIFO drained over a valid/ready handshake. It also tracks which chip IDs have reported, so the tester knows when the whole stack has been collected.

---
 rtl/chain_collector.sv | 137 +++++++++++++
 tb/tb_chain_collector.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chain_collector.sv
// Far-end chain receiver: deserialises 15-bit per-chip report frames, checks
// parity/stop, buffers good records in a show-ahead FIFO and tracks reporting IDs.
module chain_collector #(
    parameter int N_CHIPS    = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          t_clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          data_in,
    output logic                          rec_valid,
    input  logic                          rec_ready,
    output logic [3:0]                    rec_chip_id,
    output logic [3:0]                    rec_power_upper,
    output logic [3:0]                    rec_power_lower,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [15:0]                   seen_map,
    output logic                          all_collected
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [3:0] chip_id;
        logic [3:0] power_upper;
        logic [3:0] power_lower;
    } rec_t;

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_STOP, S_WAIT} state_t;

    state_t          state;
    logic [3:0]      bit_cnt;
    logic [11:0]     shreg;
    logic            par_bit;
    rec_t            mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            pop, full, good_frame, push;
    rec_t            head;

    assign rec_valid  = (count != '0);
    assign pop        = rec_valid && rec_ready;
    assign full       = (count == CW'(FIFO_DEPTH));
    assign good_frame = (state == S_STOP) && !data_in && ((^shreg) == par_bit);
    // A full FIFO still accepts the push when the head leaves on the same edge.
    assign push       = good_frame && !clear && (!full || pop);

    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            seen_map   <= '0;
        end else if (clear) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            seen_map   <= '0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                S_IDLE: if (data_in) begin
                    state   <= S_DATA;
                    bit_cnt <= '0;
                end
                S_DATA: begin
                    shreg   <= {shreg[10:0], data_in};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd11) state <= S_PARITY;
                end
                S_PARITY: begin
                    par_bit <= data_in;
                    state   <= S_STOP;
                end
                S_STOP: begin
                    // A bad stop bit wins over a parity error and forces a wait for line idle.
                    if (data_in) begin
                        frame_err <= 1'b1;
                        state     <= S_WAIT;
                    end else begin
                        state <= S_IDLE;
                        if (good_frame) begin
                            seen_map[shreg[11:8]] <= 1'b1;
                            if (full && !pop) overflow <= 1'b1;
                        end else begin
                            parity_err <= 1'b1;
                        end
                    end
                end
                S_WAIT: if (!data_in) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge t_clk) begin
        if (push) mem[wr_ptr] <= rec_t'(shreg);
    end

    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head            = rec_valid ? mem[rd_ptr] : '0;
    assign rec_chip_id     = head.chip_id;
    assign rec_power_upper = head.power_upper;
    assign rec_power_lower = head.power_lower;
    assign fifo_count      = count;
    assign all_collected   = &seen_map[N_CHIPS-1:0];

endmodule

// File: tb/tb_chain_collector.sv
// Bench for chain_collector: frame table, directed corner sequences and random
// frames, all checked every cycle against a queue-based reference model.
module tb_chain_collector;
    localparam int N_CHIPS    = 8;
    localparam int FIFO_DEPTH = 8;

    logic        t_clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clear = 1'b0;
    logic        data_in = 1'b0;
    logic        rec_ready = 1'b0;
    logic        rec_valid;
    logic [3:0]  rec_chip_id, rec_power_upper, rec_power_lower;
    logic [3:0]  fifo_count;
    logic        parity_err, frame_err, overflow, all_collected;
    logic [15:0] seen_map;

    chain_collector #(.N_CHIPS(N_CHIPS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .t_clk(t_clk), .rst_n(rst_n), .clear(clear), .data_in(data_in),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_chip_id(rec_chip_id), .rec_power_upper(rec_power_upper),
        .rec_power_lower(rec_power_lower), .fifo_count(fifo_count),
        .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow),
        .seen_map(seen_map), .all_collected(all_collected)
    );

    always #5 t_clk = ~t_clk;

    typedef struct packed {
        logic [3:0] id;
        logic [3:0] up;
        logic [3:0] lo;
    } rec_t;

    typedef struct {
        logic [3:0] id, up, lo;
        logic       pflip, stopb;
        logic       exp_perr, exp_ferr;
        int         exp_cnt;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    rec_t        mq[$];
    logic [15:0] m_seen;
    logic        m_ovf, m_perr, m_ferr;
    int          rdy_mode = 0;
    logic        rdy_stop = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_seen = '0;
        m_ovf  = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic model_check();
        rec_t h;
        h = '0;
        if (mq.size() > 0) h = mq[0];
        chk("rec_valid", rec_valid, mq.size() > 0);
        chk("fifo_count", fifo_count, mq.size());
        chk("rec_chip_id", rec_chip_id, h.id);
        chk("rec_power_upper", rec_power_upper, h.up);
        chk("rec_power_lower", rec_power_lower, h.lo);
        chk("seen_map", seen_map, m_seen);
        chk("all_collected", all_collected, &m_seen[N_CHIPS-1:0]);
        chk("overflow", overflow, m_ovf);
        chk("parity_err", parity_err, m_perr);
        chk("frame_err", frame_err, m_ferr);
    endtask

    // ev: 0 none, 1 good frame ends here, 2 parity error, 3 stop-bit error
    task automatic cyc(input logic b, input int ev, input rec_t r, input logic clr);
        logic pop;
        data_in = b;
        clear   = clr;
        case (rdy_mode)
            0:       rec_ready = 1'b0;
            1:       rec_ready = 1'b1;
            default: rec_ready = 1'($urandom_range(0, 1));
        endcase
        if (ev != 0 && rdy_stop) rec_ready = 1'b1;
        pop = rec_ready && (mq.size() > 0);
        @(posedge t_clk);
        #1;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        if (clr) begin
            model_reset();
        end else begin
            if (pop) void'(mq.pop_front());
            if (ev == 1) begin
                m_seen[r.id] = 1'b1;
                if (mq.size() < FIFO_DEPTH) mq.push_back(r);
                else m_ovf = 1'b1;
            end else if (ev == 2) m_perr = 1'b1;
            else if (ev == 3) m_ferr = 1'b1;
        end
        model_check();
        clear = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] id, input logic [3:0] up, input logic [3:0] lo,
                              input logic pflip, input logic stopb);
        logic [11:0] d;
        rec_t        r;
        int          ev;
        d  = {id, up, lo};
        r  = {id, up, lo};
        ev = stopb ? 3 : (pflip ? 2 : 1);
        cyc(1'b1, 0, r, 1'b0);
        for (int i = 11; i >= 0; i--) cyc(d[i], 0, r, 1'b0);
        cyc((^d) ^ pflip, 0, r, 1'b0);
        cyc(stopb, ev, r, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, '0, 1'b0);
    endtask

    task automatic do_clear();
        cyc(1'b0, 0, '0, 1'b1);
    endtask

    initial begin
        vec_t vt[6];
        vt[0] = '{4'h3, 4'hA, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vt[1] = '{4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vt[2] = '{4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        vt[3] = '{4'h5, 4'h5, 4'h5, 1'b0, 1'b1, 1'b0, 1'b1, 0};
        vt[4] = '{4'h9, 4'h1, 4'h2, 1'b1, 1'b1, 1'b0, 1'b1, 0};
        vt[5] = '{4'hC, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1};

        model_reset();
        #2 rst_n = 1'b0;
        #1 model_check();
        cyc(1'b0, 0, '0, 1'b0);
        cyc(1'b0, 0, '0, 1'b0);
        rst_n = 1'b1;
        idle(7);

        // Single frame, consumer stalled
        send_frame(4'h3, 4'hA, 4'h5, 1'b0, 1'b0);
        chk("s1_valid", rec_valid, 1);
        chk("s1_id", rec_chip_id, 4'h3);
        chk("s1_upper", rec_power_upper, 4'hA);
        chk("s1_lower", rec_power_lower, 4'h5);
        chk("s1_seen", seen_map, 16'h0008);
        chk("s1_count", fifo_count, 1);
        idle(2);

        // Frame table
        for (int k = 0; k < 6; k++) begin
            do_clear();
            send_frame(vt[k].id, vt[k].up, vt[k].lo, vt[k].pflip, vt[k].stopb);
            chk("tbl_perr", parity_err, vt[k].exp_perr);
            chk("tbl_ferr", frame_err, vt[k].exp_ferr);
            chk("tbl_count", fifo_count, vt[k].exp_cnt);
            if (vt[k].exp_cnt != 0) chk("tbl_head_id", rec_chip_id, vt[k].id);
            idle(1);
            chk("tbl_perr_off", parity_err, 0);
            chk("tbl_ferr_off", frame_err, 0);
        end

        // Eight back-to-back frames, consumer always ready
        do_clear();
        rdy_mode = 1;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) chk("b2b_pre_all", all_collected, 0);
            send_frame(4'(k), 4'(k + 1), 4'(15 - k), 1'b0, 1'b0);
        end
        chk("b2b_all", all_collected, 1);
        chk("b2b_seen", seen_map, 16'h00FF);
        chk("b2b_ovf", overflow, 0);
        idle(2);
        chk("b2b_drained", fifo_count, 0);
        rdy_mode = 0;

        // Parity error
        do_clear();
        send_frame(4'h3, 4'hA, 4'h5, 1'b1, 1'b0);
        chk("par_pulse", parity_err, 1);
        idle(1);
        chk("par_pulse_end", parity_err, 0);
        chk("par_count", fifo_count, 0);
        chk("par_seen", seen_map, 0);

        // Stop error, line held high, then a good frame
        do_clear();
        send_frame(4'h2, 4'h4, 4'h6, 1'b0, 1'b1);
        chk("stop_pulse", frame_err, 1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 0, '0, 1'b0);
        cyc(1'b0, 0, '0, 1'b0);
        chk("stop_no_push", fifo_count, 0);
        send_frame(4'h6, 4'h1, 4'h7, 1'b0, 1'b0);
        chk("stop_recover", rec_chip_id, 4'h6);

        // Overflow, then a push on a full FIFO with simultaneous pop
        do_clear();
        for (int k = 0; k < 9; k++) send_frame(4'(k), 4'hB, 4'(k), 1'b0, 1'b0);
        chk("ovf_count", fifo_count, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", rec_chip_id, 4'h0);
        chk("ovf_seen", seen_map, 16'h01FF);
        rdy_stop = 1'b1;
        send_frame(4'hE, 4'hD, 4'hC, 1'b0, 1'b0);
        rdy_stop = 1'b0;
        chk("full_pop_count", fifo_count, 8);
        chk("full_pop_head", rec_chip_id, 4'h1);

        // Reset mid-frame
        cyc(1'b1, 0, '0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'($urandom_range(0, 1)), 0, '0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1 model_check();
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, '0, 1'b0);
        rst_n = 1'b1;
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        send_frame(4'h4, 4'h9, 4'h2, 1'b0, 1'b0);
        chk("rst_after_id", rec_chip_id, 4'h4);
        chk("rst_after_up", rec_power_upper, 4'h9);

        // Clear mid-frame
        cyc(1'b1, 0, '0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 0, '0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, '0, 1'b1);
        chk("clr_count", fifo_count, 0);
        chk("clr_seen", seen_map, 0);
        send_frame(4'h7, 4'h8, 4'h1, 1'b0, 1'b0);
        chk("clr_after_id", rec_chip_id, 4'h7);
        chk("clr_after_lo", rec_power_lower, 4'h1);

        // Random frames, random consumer stalls
        do_clear();
        rdy_mode = 2;
        for (int k = 0; k < 40; k++) begin
            int kind;
            kind = $urandom_range(0, 9);
            send_frame(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), kind == 7 || kind == 8, kind == 9);
            if (kind == 9) begin
                for (int i = $urandom_range(0, 3); i > 0; i--) cyc(1'b1, 0, '0, 1'b0);
                cyc(1'b0, 0, '0, 1'b0);
            end
            idle($urandom_range(0, 2));
        end
        rdy_mode = 1;
        idle(10);
        chk("final_drain", fifo_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
